// File: rtl/libtech.sv
// Shared technology definitions: DSP48E control encodings and the step tags
// used by the sequenced 32x32 multiplier.
package libtech;

  typedef struct packed {
    logic [6:0] opmode;
    logic [3:0] alumode;
  } dsp_ctrl_type;

  // OPMODE = {Z[2:0], Y[1:0], X[1:0]}; X=Y=01 selects M, Z picks the accumulate term
  localparam dsp_ctrl_type DSP_MUL1 = '{opmode: 7'b000_0101, alumode: 4'b0000};  // M
  localparam dsp_ctrl_type DSP_MUL2 = '{opmode: 7'b110_0101, alumode: 4'b0000};  // M + P>>17
  localparam dsp_ctrl_type DSP_MUL3 = '{opmode: 7'b010_0101, alumode: 4'b0000};  // M + P
  localparam dsp_ctrl_type DSP_MUL4 = '{opmode: 7'b110_0101, alumode: 4'b0000};  // M + P>>17

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP1,
    STEP2,
    STEP3,
    STEP4
  } dsp_mul_step_type;

  typedef enum logic [2:0] {
    IDLE,
    S1,
    S2,
    S3,
    S4,
    DRAIN,
    HOLD
  } dsp_mul_state_type;

  function automatic logic [24:0] hi_a(input logic [14:0] h, input logic sgn);
    return {{10{sgn & h[14]}}, h};
  endfunction

  function automatic logic [17:0] hi_b(input logic [14:0] h, input logic sgn);
    return {{3{sgn & h[14]}}, h};
  endfunction

endpackage

// File: rtl/dsp_mul_tagpipe.sv
// Step-tag delay line matching the DSP result latency; the exiting tag says
// which partial product is currently on dsp_p.
module dsp_mul_tagpipe
  import libtech::*;
#(
  parameter int DSP_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  dsp_mul_step_type tag_in,
  output dsp_mul_step_type tag_out
);

  dsp_mul_step_type pipe [DSP_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DSP_LAT; i++) pipe[i] <= STEP_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DSP_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DSP_LAT-1];

endmodule

// File: rtl/dsp_mul_seq.sv
// Four-step 32x32 multiply sequenced through one DSP48E slice.
// Define DSP_MUL_SIGNED_EN to add the req_signed port (two's-complement operands).
// States: IDLE wait | S1..S4 drive one partial product each | DRAIN wait last result | HOLD present product
module dsp_mul_seq
  import libtech::*;
#(
  parameter int DSP_LAT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
`ifdef DSP_MUL_SIGNED_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_prod,
  output logic        busy,
  output logic [24:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [6:0]  dsp_opmode,
  output logic [3:0]  dsp_alumode,
  input  logic [47:0] dsp_p
);

  dsp_mul_state_type state, state_nxt;
  dsp_ctrl_type      ctrl_q, ctrl_nxt;
  dsp_mul_step_type  tag_q, tag_nxt, tag_out;
  logic [24:0]       a_nxt;
  logic [17:0]       b_nxt;
  logic [31:0]       a_q, b_q;
  logic              sgn_q, sgn_in, last_cap, accept;
  logic              p_unused;

`ifdef DSP_MUL_SIGNED_EN
  assign sgn_in = req_signed;
`else
  assign sgn_in = 1'b0;
`endif

  assign accept   = req_valid & req_ready;
  assign p_unused = ^dsp_p[47:30];

  always_comb begin
    state_nxt = state;
    a_nxt     = dsp_a;
    b_nxt     = dsp_b;
    ctrl_nxt  = ctrl_q;
    tag_nxt   = STEP_NONE;
    case (state)
      IDLE: if (accept) begin
        state_nxt = S1;
        a_nxt     = {8'b0, req_a[16:0]};
        b_nxt     = {1'b0, req_b[16:0]};
        ctrl_nxt  = DSP_MUL1;
        tag_nxt   = STEP1;
      end
      S1: begin
        state_nxt = S2;
        a_nxt     = {8'b0, a_q[16:0]};
        b_nxt     = hi_b(b_q[31:17], sgn_q);
        ctrl_nxt  = DSP_MUL2;
        tag_nxt   = STEP2;
      end
      S2: begin
        state_nxt = S3;
        a_nxt     = hi_a(a_q[31:17], sgn_q);
        b_nxt     = {1'b0, b_q[16:0]};
        ctrl_nxt  = DSP_MUL3;
        tag_nxt   = STEP3;
      end
      S3: begin
        state_nxt = S4;
        a_nxt     = hi_a(a_q[31:17], sgn_q);
        b_nxt     = hi_b(b_q[31:17], sgn_q);
        ctrl_nxt  = DSP_MUL4;
        tag_nxt   = STEP4;
      end
      S4:      state_nxt = DRAIN;
      DRAIN:   if (last_cap) state_nxt = HOLD;
      HOLD:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      ctrl_q    <= DSP_MUL1;
      tag_q     <= STEP_NONE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      dsp_a     <= a_nxt;
      dsp_b     <= b_nxt;
      ctrl_q    <= ctrl_nxt;
      tag_q     <= tag_nxt;
      if (accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        sgn_q <= sgn_in;
      end
    end
  end

  // tag_q travels with the dsp_* registers, so the pipe exit lines up with dsp_p
  dsp_mul_tagpipe #(.DSP_LAT(DSP_LAT)) u_tagpipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (tag_q),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_prod <= '0;
      last_cap  <= 1'b0;
    end else begin
      last_cap <= (tag_out == STEP4);
      case (tag_out)
        STEP1:   resp_prod[16:0]  <= dsp_p[16:0];
        STEP3:   resp_prod[33:17] <= dsp_p[16:0];
        STEP4:   resp_prod[63:34] <= dsp_p[29:0];
        default: ;
      endcase
    end
  end

  assign resp_valid  = (state == HOLD);
  assign busy        = (state != IDLE);
  assign dsp_opmode  = ctrl_q.opmode;
  assign dsp_alumode = ctrl_q.alumode;

endmodule

// File: tb/tb_dsp_mul_seq.sv
// Self-checking bench for dsp_mul_seq: behavioural DSP48E model on dsp_p and a
// plain-arithmetic product reference. TB_DSP_LAT selects the DSP latency build.
module tb_dsp_mul_seq #(
  parameter int TB_DSP_LAT = 2
);

  localparam int LAT = TB_DSP_LAT;
  localparam int PI = (LAT >= 2) ? LAT - 2 : 0;
`ifdef DSP_MUL_SIGNED_EN
  localparam bit HAS_SGN = 1'b1;
`else
  localparam bit HAS_SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
`ifdef DSP_MUL_SIGNED_EN
  logic        req_signed = 1'b0;
`endif
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_prod;
  logic        busy;
  logic [24:0] dsp_a;
  logic [17:0] dsp_b;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [47:0] dsp_p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dsp_mul_seq #(.DSP_LAT(LAT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
`ifdef DSP_MUL_SIGNED_EN
    .req_signed  (req_signed),
`endif
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_prod   (resp_prod),
    .busy        (busy),
    .dsp_a       (dsp_a),
    .dsp_b       (dsp_b),
    .dsp_opmode  (dsp_opmode),
    .dsp_alumode (dsp_alumode),
    .dsp_p       (dsp_p)
  );

  // DSP48E model: LAT-1 input register stages, then the P register
  logic [24:0] ra   [4];
  logic [17:0] rb   [4];
  logic [6:0]  rop  [4];
  logic [3:0]  ralu [4];
  logic [47:0] p_q = '0;
  assign dsp_p = p_q;

  function automatic logic [47:0] dsp_eval(input logic [24:0] a, input logic [17:0] b,
                                           input logic [6:0] op, input logic [3:0] alu,
                                           input logic [47:0] p);
    longint m, z, pp;
    if (op[3:0] != 4'b0101 || alu != 4'b0000) return '0;
    m  = longint'($signed(a)) * longint'($signed(b));
    pp = longint'($signed(p));
    case (op[6:4])
      3'b010:  z = pp;
      3'b110:  z = pp >>> 17;
      default: z = 0;
    endcase
    return 48'(m + z);
  endfunction

  always @(posedge clk) begin
    if (LAT == 1) p_q <= dsp_eval(dsp_a, dsp_b, dsp_opmode, dsp_alumode, p_q);
    else          p_q <= dsp_eval(ra[PI], rb[PI], rop[PI], ralu[PI], p_q);
    ra[0] <= dsp_a; rb[0] <= dsp_b; rop[0] <= dsp_opmode; ralu[0] <= dsp_alumode;
    for (int k = 1; k < 4; k++) begin
      ra[k] <= ra[k-1]; rb[k] <= rb[k-1]; rop[k] <= rop[k-1]; ralu[k] <= ralu[k-1];
    end
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    req_a = a;
    req_b = b;
`ifdef DSP_MUL_SIGNED_EN
    req_signed = sgn;
`endif
    req_valid = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    ok = (req_ready === 1'b1);
  endtask

  // Full transaction; the calling point is always 1 time unit after a posedge.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input int hold_cyc, output logic [63:0] prod, output int lat);
    bit rdy;
    wait_ready(rdy);
    drive_req(a, b, sgn);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    prod = resp_prod;
    n_tests++;
    if (!rdy || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake: ready=%0b resp_valid=%b, required both seen", rdy, resp_valid);
    end
    repeat (hold_cyc) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #2;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (resp_prod !== 64'h0) begin n_fail++; $display("FAIL reset_resp_prod: got %h want 0", resp_prod); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (dsp_a !== 25'h0 || dsp_b !== 18'h0) begin n_fail++; $display("FAIL reset_dsp_ab: got %h/%h want 0/0", dsp_a, dsp_b); end
    n_tests++; if (dsp_opmode !== 7'h05 || dsp_alumode !== 4'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h/%h want 05/0", dsp_opmode, dsp_alumode); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_held_ready: got %b want 0", req_ready); end
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: ready=%b busy=%b want 1/0", req_ready, busy); end
  endtask

  task automatic test_directed;
    logic [63:0] p;
    int lat;
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, p, lat);
    n_tests++; if (p !== 64'hFFFFFFFE00000001) begin n_fail++; $display("FAIL ones_unsigned: got %h want fffffffe00000001", p); end
    n_tests++; if (lat != 5 + LAT) begin n_fail++; $display("FAIL latency: got %0d want %0d", lat, 5 + LAT); end
    do_mul(32'h00012345, 32'h0, 1'b0, 0, p, lat);
    n_tests++; if (p !== 64'h0) begin n_fail++; $display("FAIL times_zero: got %h want 0", p); end
    do_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 2, p, lat);
    n_tests++; if (p !== ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0)) begin n_fail++; $display("FAIL mid_pattern: got %h want %h", p, ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0)); end
    if (HAS_SGN) begin
      do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, p, lat);
      n_tests++; if (p !== 64'h1) begin n_fail++; $display("FAIL signed_m1_m1: got %h want 1", p); end
      do_mul(32'h80000000, 32'h80000000, 1'b1, 0, p, lat);
      n_tests++; if (p !== 64'h4000000000000000) begin n_fail++; $display("FAIL signed_min_min: got %h want 4000000000000000", p); end
      do_mul(32'h80000000, 32'h00000002, 1'b1, 1, p, lat);
      n_tests++; if (p !== 64'hFFFFFFFF00000000) begin n_fail++; $display("FAIL signed_min_2: got %h want ffffffff00000000", p); end
    end
  endtask

  task automatic test_op_sequence;
    logic [31:0] a, b;
    bit sgn, rdy;
    logic [24:0] al, ah;
    logic [17:0] bl, bh;
    logic [24:0] ea [4];
    logic [17:0] eb [4];
    logic [6:0]  eop [4];
    int lat;
    a = $urandom | 32'h80000000;
    b = $urandom | 32'h80000000;
    sgn = HAS_SGN;
    al = {8'b0, a[16:0]};
    bl = {1'b0, b[16:0]};
    ah = sgn ? {{10{a[31]}}, a[31:17]} : {10'b0, a[31:17]};
    bh = sgn ? {{3{b[31]}}, b[31:17]} : {3'b0, b[31:17]};
    ea = '{al, al, ah, ah};
    eb = '{bl, bh, bl, bh};
    eop = '{7'h05, 7'h65, 7'h25, 7'h65};
    wait_ready(rdy);
    drive_req(a, b, sgn);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_tests++;
      if (dsp_opmode !== eop[s] || dsp_alumode !== 4'h0 || dsp_a !== ea[s] || dsp_b !== eb[s]) begin
        n_fail++;
        $display("FAIL op_step%0d: got op=%h alu=%h a=%h b=%h want op=%h alu=0 a=%h b=%h",
                 s + 1, dsp_opmode, dsp_alumode, dsp_a, dsp_b, eop[s], ea[s], eb[s]);
      end
      @(posedge clk); #1;
    end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    n_tests++;
    if (resp_valid !== 1'b1 || resp_prod !== ref_mul(a, b, sgn)) begin
      n_fail++;
      $display("FAIL op_seq_product: got %h valid=%b want %h", resp_prod, resp_valid, ref_mul(a, b, sgn));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] p0, p;
    bit rdy;
    int lat;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    wait_ready(rdy);
    drive_req(a1, b1, 1'b0);
    @(posedge clk); #1;
    drive_req(a2, b2, 1'b0);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    p0 = resp_prod;
    n_tests++; if (p0 !== ref_mul(a1, b1, 1'b0)) begin n_fail++; $display("FAIL bp_product: got %h want %h", p0, ref_mul(a1, b1, 1'b0)); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_prod !== p0 || req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b prod=%h ready=%b busy=%b want 1/%h/0/1", i, resp_valid, resp_prod, req_ready, busy, p0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b busy=%b want 0/1/0", resp_valid, req_ready, busy); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept: busy=%b ready=%b want 1/0", busy, req_ready); end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    p = resp_prod;
    n_tests++; if (resp_valid !== 1'b1 || p !== ref_mul(a2, b2, 1'b0)) begin n_fail++; $display("FAIL bp_second: got %h want %h", p, ref_mul(a2, b2, 1'b0)); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [63:0] p;
    bit rdy;
    int lat;
    wait_ready(rdy);
    drive_req($urandom, $urandom, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (dsp_opmode !== 7'h25 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_s3: op=%h busy=%b want 25/1", dsp_opmode, busy); end
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_prod !== 64'h0 || busy !== 1'b0 ||
        dsp_a !== 25'h0 || dsp_b !== 18'h0 || dsp_opmode !== 7'h05 || dsp_alumode !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b prod=%h busy=%b a=%h b=%h op=%h alu=%h want all reset",
               req_ready, resp_valid, resp_prod, busy, dsp_a, dsp_b, dsp_opmode, dsp_alumode);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    do_mul(32'd3, 32'd5, 1'b0, 0, p, lat);
    n_tests++; if (p !== 64'hF) begin n_fail++; $display("FAIL mid_after_reset: got %h want f", p); end
    n_tests++; if (lat != 5 + LAT) begin n_fail++; $display("FAIL mid_latency: got %0d want %0d", lat, 5 + LAT); end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [63:0] p;
    bit sgn;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h0001FFFF;
        1: b = 32'hFFFE0000;
        2: a = 32'h7FFFFFFF;
        default: ;
      endcase
      sgn = HAS_SGN ? bit'($urandom_range(0, 1)) : 1'b0;
      do_mul(a, b, sgn, $urandom_range(0, 3), p, lat);
      n_tests++;
      if (p !== ref_mul(a, b, sgn) || lat != 5 + LAT) begin
        n_fail++;
        $display("FAIL rand%0d: %h*%h s=%0b got %h lat %0d want %h lat %0d", i, a, b, sgn, p, lat, ref_mul(a, b, sgn), 5 + LAT);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_op_sequence;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
